// File: rtl/mult_ctrl_pkg.sv
// mult_ctrl_pkg: shared state encodings and sizing constants for the shift-add multiplier
package mult_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        TEST  = 3'd2,
        SHIFT = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam int N_DEF = 4;
    localparam int ACC_W = N_DEF * 2 + 1;

endpackage

// File: rtl/mult_step_counter.sv
// mult_step_counter: counts shift steps of one product and flags the final step
module mult_step_counter #(
    parameter int N     = 4,
    parameter int CNT_W = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic last
);

    logic [CNT_W-1:0] count;

    // wraps to zero on the final step so the next product starts clean
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count <= '0;
        else if (clr || (en && last))
            count <= '0;
        else if (en)
            count <= count + 1'b1;
    end

    assign last = (count == CNT_W'(N - 1));

endmodule

// File: rtl/mult_ctrl.sv
// mult_ctrl: shift-add multiplier control FSM; MULT_CTRL_ACK_EN adds an Ack handshake in DONE
module mult_ctrl
    import mult_ctrl_pkg::*;
#(
    parameter int N = N_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic m,
`ifdef MULT_CTRL_ACK_EN
    input  logic ack,
`endif
    output logic load,
    output logic ad,
    output logic sh,
    output logic busy,
    output logic done
);

    localparam int CNT_W = $clog2(N + 1);

    state_t state;
    logic   last;

    mult_step_counter #(.N(N), .CNT_W(CNT_W)) u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (state == IDLE),
        .en    (sh),
        .last  (last)
    );

    // state register and next-state selection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            case (state)
                IDLE:    state <= start ? LOAD : IDLE;
                LOAD:    state <= TEST;
                TEST:    state <= m ? SHIFT : (last ? DONE : TEST);
                SHIFT:   state <= last ? DONE : TEST;
`ifdef MULT_CTRL_ACK_EN
                DONE:    state <= ack ? IDLE : DONE;
`else
                DONE:    state <= IDLE;
`endif
                default: state <= IDLE;
            endcase
    end

    // strobes decode from the state register; only TEST looks at m
    always_comb begin
        load = (state == LOAD);
        ad   = (state == TEST) && m;
        sh   = ((state == TEST) && !m) || (state == SHIFT);
        busy = (state != IDLE);
        done = (state == DONE);
    end

endmodule
